// File: rtl/targ_predictor_pkg.sv
// Shared address type, instruction-alignment helper and target-predictor bus payloads.
package sys;
  localparam int unsigned addr_w = 32;
  typedef logic [addr_w-1:0] addr_t;
endpackage

package util;
  // Clears the byte offset so targets land on 4-byte instruction boundaries
  function automatic sys::addr_t align_inst(input sys::addr_t pc);
    return pc & ~sys::addr_t'(3);
  endfunction
endpackage

package core;
  localparam int unsigned peval_width = 2;
  localparam int unsigned targ_cnt_w  = $clog2(peval_width + 1);
  localparam int unsigned tag_w       = sys::addr_w - 2;

  typedef struct packed {
    logic       valid;
    sys::addr_t base_pc;
  } targ_pred_req_t;

  typedef struct packed {
    logic       valid;
    sys::addr_t base_pc;
    sys::addr_t targ_pc;
  } targ_pred_fb_t;

  typedef struct packed {
    logic [targ_cnt_w-1:0]        targ_cnt;
    sys::addr_t [peval_width-1:0] targ_list;
  } targ_pred_rsp_t;

  localparam targ_pred_req_t targ_pred_req_rst = '0;
  localparam targ_pred_fb_t  targ_pred_fb_rst  = '0;
  localparam targ_pred_rsp_t targ_pred_rsp_rst = '0;
endpackage

// File: rtl/targ_predictor_if.sv
// Lookup, feedback and response bundle between the pipe manager and the target predictor.
interface targ_predictor_if;
  import core::*;

  targ_pred_req_t targ_pred_req [peval_width];
  targ_pred_fb_t  targ_pred_fb;
  targ_pred_rsp_t targ_pred_rsp [peval_width];

  modport master (output targ_pred_req, output targ_pred_fb, input targ_pred_rsp);
  modport slave  (input targ_pred_req, input targ_pred_fb, output targ_pred_rsp);
endinterface

// File: rtl/targ_pred_mru_list.sv
// One predictor entry's MRU-ordered target list; valid slots stay packed from slot 0.
module targ_pred_mru_list
  import core::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         upd_en,
  input  logic                         alloc,
  input  sys::addr_t                   targ,
  output sys::addr_t [peval_width-1:0] slot,
  output logic [peval_width-1:0]       slot_vld
);

  sys::addr_t [peval_width-1:0] slot_nxt;
  logic [peval_width-1:0]       vld_nxt;
  logic [peval_width-1:0]       match;
  logic                         hit;

  always_comb begin
    for (int i = 0; i < int'(peval_width); i++) begin
      match[i] = slot_vld[i] && (slot[i] == targ);
    end
  end

  assign hit = |match;

  // Slots younger than the matching one (or all slots on insert) age by one position
  always_comb begin
    slot_nxt = slot;
    vld_nxt  = slot_vld;
    if (upd_en && alloc) begin
      slot_nxt    = '0;
      vld_nxt     = '0;
      slot_nxt[0] = targ;
      vld_nxt[0]  = 1'b1;
    end else if (upd_en) begin
      for (int i = 1; i < int'(peval_width); i++) begin
        if (!hit || ((match >> i) != '0)) begin
          slot_nxt[i] = slot[i-1];
          vld_nxt[i]  = slot_vld[i-1];
        end
      end
      slot_nxt[0] = targ;
      vld_nxt[0]  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      slot_vld <= '0;
    end else begin
      slot     <= slot_nxt;
      slot_vld <= vld_nxt;
    end
  end

endmodule

// File: rtl/targ_predictor.sv
// Fully associative JALR target predictor: tag CAM, allocator, round-robin replacement
// and per-lane combinational read muxes over a set of MRU target lists.
module targ_predictor
  import core::*;
#(
  parameter int unsigned entry_cnt = 16
) (
  input  logic             clk,
  input  logic             rst,
  targ_predictor_if.slave  bus
);

  localparam int unsigned ptr_w = $clog2(entry_cnt);

  logic [entry_cnt-1:0]         ent_vld;
  logic [tag_w-1:0]             ent_tag      [entry_cnt];
  sys::addr_t [peval_width-1:0] ent_slot     [entry_cnt];
  logic [peval_width-1:0]       ent_slot_vld [entry_cnt];
  logic [targ_cnt_w-1:0]        ent_cnt      [entry_cnt];
  logic [ptr_w-1:0]             repl_ptr;

  logic [tag_w-1:0]     fb_tag;
  sys::addr_t           fb_targ;
  logic                 fb_valid;
  logic [entry_cnt-1:0] fb_hit;
  logic                 fb_hit_any;
  logic                 free_any;
  logic [ptr_w-1:0]     free_idx;
  logic [ptr_w-1:0]     alloc_idx;
  logic [entry_cnt-1:0] alloc_en;
  logic [entry_cnt-1:0] upd_en;
  logic                 repl_used;

  assign fb_valid = bus.targ_pred_fb.valid;
  assign fb_tag   = bus.targ_pred_fb.base_pc[sys::addr_w-1:2];
  assign fb_targ  = util::align_inst(bus.targ_pred_fb.targ_pc);

  always_comb begin
    for (int e = 0; e < int'(entry_cnt); e++) begin
      fb_hit[e] = ent_vld[e] && (ent_tag[e] == fb_tag);
    end
  end

  assign fb_hit_any = |fb_hit;

  // Lowest-index free entry takes priority over the round-robin victim
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int e = 0; e < int'(entry_cnt); e++) begin
      if (!ent_vld[e] && !free_any) begin
        free_any = 1'b1;
        free_idx = ptr_w'(e);
      end
    end
  end

  assign alloc_idx = free_any ? free_idx : repl_ptr;
  assign repl_used = fb_valid && !fb_hit_any && !free_any;

  always_comb begin
    for (int e = 0; e < int'(entry_cnt); e++) begin
      alloc_en[e] = fb_valid && !fb_hit_any && (alloc_idx == ptr_w'(e));
      upd_en[e]   = (fb_valid && fb_hit[e]) || alloc_en[e];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld  <= '0;
      repl_ptr <= '0;
      for (int e = 0; e < int'(entry_cnt); e++) begin
        ent_tag[e] <= '0;
      end
    end else begin
      for (int e = 0; e < int'(entry_cnt); e++) begin
        if (alloc_en[e]) begin
          ent_vld[e] <= 1'b1;
          ent_tag[e] <= fb_tag;
        end
      end
      if (repl_used) begin
        repl_ptr <= (repl_ptr == ptr_w'(entry_cnt - 1)) ? '0 : repl_ptr + ptr_w'(1);
      end
    end
  end

  for (genvar e = 0; e < entry_cnt; e++) begin : g_ent
    targ_pred_mru_list u_list (
      .clk      (clk),
      .rst      (rst),
      .upd_en   (upd_en[e]),
      .alloc    (alloc_en[e]),
      .targ     (fb_targ),
      .slot     (ent_slot[e]),
      .slot_vld (ent_slot_vld[e])
    );
  end

  always_comb begin
    for (int e = 0; e < int'(entry_cnt); e++) begin
      ent_cnt[e] = '0;
      for (int k = 0; k < int'(peval_width); k++) begin
        ent_cnt[e] = ent_cnt[e] + targ_cnt_w'(ent_slot_vld[e][k]);
      end
    end
  end

  // Tag uniqueness lets the read mux OR the single matching entry into each lane
  always_comb begin
    for (int l = 0; l < int'(peval_width); l++) begin
      bus.targ_pred_rsp[l] = targ_pred_rsp_rst;
      if (!rst && bus.targ_pred_req[l].valid) begin
        for (int e = 0; e < int'(entry_cnt); e++) begin
          if (ent_vld[e] && (ent_tag[e] == bus.targ_pred_req[l].base_pc[sys::addr_w-1:2])) begin
            bus.targ_pred_rsp[l].targ_cnt = bus.targ_pred_rsp[l].targ_cnt | ent_cnt[e];
            for (int k = 0; k < int'(peval_width); k++) begin
              if (ent_slot_vld[e][k]) begin
                bus.targ_pred_rsp[l].targ_list[k] = bus.targ_pred_rsp[l].targ_list[k] | ent_slot[e][k];
              end
            end
          end
        end
      end
    end
  end

  logic [2*peval_width+1:0] unused_pc_lsb;
  always_comb begin
    unused_pc_lsb[1:0] = bus.targ_pred_fb.base_pc[1:0];
    for (int l = 0; l < int'(peval_width); l++) begin
      unused_pc_lsb[2*l+2 +: 2] = bus.targ_pred_req[l].base_pc[1:0];
    end
  end

endmodule

// File: tb/tb_targ_predictor.sv
// Randomized and directed checks of targ_predictor against a queue-based reference model.
module tb_targ_predictor;
  import core::*;

  localparam int unsigned entry_cnt = 4;
  localparam int          pw        = int'(peval_width);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  targ_predictor_if bus ();

  targ_predictor #(.entry_cnt(entry_cnt)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per entry a tag and an MRU list kept as a queue
  bit          m_vld  [entry_cnt];
  logic [29:0] m_tag  [entry_cnt];
  sys::addr_t  m_targ [entry_cnt][pw];
  int          m_cnt  [entry_cnt];
  int          m_ptr;

  task automatic model_reset();
    for (int e = 0; e < int'(entry_cnt); e++) begin
      m_vld[e] = 1'b0;
      m_tag[e] = '0;
      m_cnt[e] = 0;
      for (int k = 0; k < pw; k++) m_targ[e][k] = '0;
    end
    m_ptr = 0;
  endtask

  function automatic targ_pred_rsp_t model_rsp(input targ_pred_req_t r, input logic rs);
    targ_pred_rsp_t o;
    o = '0;
    if (r.valid && !rs) begin
      for (int e = 0; e < int'(entry_cnt); e++) begin
        if (m_vld[e] && m_tag[e] == r.base_pc[31:2]) begin
          o.targ_cnt = targ_cnt_w'(m_cnt[e]);
          for (int k = 0; k < m_cnt[e]; k++) o.targ_list[k] = m_targ[e][k];
        end
      end
    end
    return o;
  endfunction

  task automatic model_update(input targ_pred_fb_t fb);
    sys::addr_t t;
    sys::addr_t q[$];
    int hit;
    int sel;
    t   = fb.targ_pc & 32'hFFFF_FFFC;
    hit = -1;
    for (int e = 0; e < int'(entry_cnt); e++)
      if (m_vld[e] && m_tag[e] == fb.base_pc[31:2]) hit = e;
    if (hit >= 0) begin
      for (int k = 0; k < m_cnt[hit]; k++)
        if (m_targ[hit][k] != t) q.push_back(m_targ[hit][k]);
      q.push_front(t);
      while (q.size() > pw) void'(q.pop_back());
      m_cnt[hit] = q.size();
      for (int k = 0; k < pw; k++) m_targ[hit][k] = (k < q.size()) ? q[k] : '0;
    end else begin
      sel = -1;
      for (int e = 0; e < int'(entry_cnt); e++)
        if (!m_vld[e] && sel < 0) sel = e;
      if (sel < 0) begin
        sel   = m_ptr;
        m_ptr = (m_ptr + 1) % int'(entry_cnt);
      end
      m_vld[sel] = 1'b1;
      m_tag[sel] = fb.base_pc[31:2];
      m_cnt[sel] = 1;
      for (int k = 0; k < pw; k++) m_targ[sel][k] = '0;
      m_targ[sel][0] = t;
    end
  endtask

  function automatic targ_pred_req_t mk_req(input logic v, input sys::addr_t pc);
    targ_pred_req_t r;
    r.valid   = v;
    r.base_pc = pc;
    return r;
  endfunction

  function automatic targ_pred_fb_t mk_fb(input logic v, input sys::addr_t b, input sys::addr_t t);
    targ_pred_fb_t f;
    f.valid   = v;
    f.base_pc = b;
    f.targ_pc = t;
    return f;
  endfunction

  // Drive one cycle's inputs on the falling edge and compare every lane with the model
  task automatic apply(input targ_pred_req_t r0, input targ_pred_req_t r1,
                       input targ_pred_fb_t fb, input logic rs);
    targ_pred_rsp_t exp;
    @(negedge clk);
    rst                  = rs;
    bus.targ_pred_req[0] = r0;
    bus.targ_pred_req[1] = r1;
    bus.targ_pred_fb     = fb;
    #1;
    for (int l = 0; l < pw; l++) begin
      exp = model_rsp(bus.targ_pred_req[l], rs);
      check($sformatf("model_l%0d_cnt", l), 64'(bus.targ_pred_rsp[l].targ_cnt), 64'(exp.targ_cnt));
      for (int k = 0; k < pw; k++)
        check($sformatf("model_l%0d_list%0d", l, k), 64'(bus.targ_pred_rsp[l].targ_list[k]),
              64'(exp.targ_list[k]));
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) model_reset();
    else if (bus.targ_pred_fb.valid) model_update(bus.targ_pred_fb);
  endtask

  task automatic step(input targ_pred_req_t r0, input targ_pred_req_t r1,
                      input targ_pred_fb_t fb, input logic rs);
    apply(r0, r1, fb, rs);
    commit();
  endtask

  task automatic expect_lane(input string tag, input int lane, input int cnt,
                             input sys::addr_t t0, input sys::addr_t t1);
    check({tag, "_cnt"}, 64'(bus.targ_pred_rsp[lane].targ_cnt), 64'(cnt));
    check({tag, "_t0"}, 64'(bus.targ_pred_rsp[lane].targ_list[0]), 64'(t0));
    check({tag, "_t1"}, 64'(bus.targ_pred_rsp[lane].targ_list[1]), 64'(t1));
  endtask

  targ_pred_req_t no_req;
  targ_pred_fb_t  no_fb;

  initial begin
    no_req = mk_req(1'b0, '0);
    no_fb  = mk_fb(1'b0, '0, '0);
    rst                  = 1'b1;
    bus.targ_pred_req[0] = no_req;
    bus.targ_pred_req[1] = no_req;
    bus.targ_pred_fb     = no_fb;
    model_reset();

    step(no_req, no_req, mk_fb(1'b1, 32'h100, 32'h5000), 1'b1);
    step(no_req, no_req, no_fb, 1'b1);

    apply(mk_req(1'b1, 32'h100), no_req, no_fb, 1'b0);
    expect_lane("reset_lookup", 0, 0, 0, 0);
    commit();

    step(no_req, no_req, mk_fb(1'b1, 32'h100, 32'h2000), 1'b0);
    step(no_req, no_req, mk_fb(1'b1, 32'h100, 32'h3002), 1'b0);
    apply(mk_req(1'b1, 32'h100), mk_req(1'b1, 32'h102), no_fb, 1'b0);
    expect_lane("learn_l0", 0, 2, 32'h3000, 32'h2000);
    expect_lane("learn_l1", 1, 2, 32'h3000, 32'h2000);
    commit();

    step(no_req, no_req, mk_fb(1'b1, 32'h100, 32'h2000), 1'b0);
    apply(mk_req(1'b1, 32'h100), no_req, no_fb, 1'b0);
    expect_lane("promote", 0, 2, 32'h2000, 32'h3000);
    commit();

    step(no_req, no_req, mk_fb(1'b1, 32'h100, 32'h3000), 1'b0);
    step(no_req, no_req, mk_fb(1'b1, 32'h100, 32'h4000), 1'b0);
    apply(mk_req(1'b1, 32'h100), no_req, no_fb, 1'b0);
    expect_lane("evict_slot", 0, 2, 32'h4000, 32'h3000);
    commit();

    step(no_req, no_req, mk_fb(1'b1, 32'h200, 32'h1000), 1'b0);
    step(no_req, no_req, mk_fb(1'b1, 32'h300, 32'h1100), 1'b0);
    step(no_req, no_req, mk_fb(1'b1, 32'h400, 32'h1200), 1'b0);
    step(no_req, no_req, mk_fb(1'b1, 32'h500, 32'h9000), 1'b0);
    apply(mk_req(1'b1, 32'h100), mk_req(1'b1, 32'h500), no_fb, 1'b0);
    expect_lane("rr_old", 0, 0, 0, 0);
    expect_lane("rr_new", 1, 1, 32'h9000, 0);
    commit();
    step(no_req, no_req, mk_fb(1'b1, 32'h600, 32'h9100), 1'b0);
    apply(mk_req(1'b1, 32'h200), mk_req(1'b1, 32'h600), no_fb, 1'b0);
    expect_lane("rr2_old", 0, 0, 0, 0);
    expect_lane("rr2_new", 1, 1, 32'h9100, 0);
    commit();

    apply(mk_req(1'b1, 32'h700), no_req, mk_fb(1'b1, 32'h700, 32'hA000), 1'b0);
    expect_lane("same_cycle", 0, 0, 0, 0);
    commit();
    apply(mk_req(1'b1, 32'h700), mk_req(1'b1, 32'h703), no_fb, 1'b0);
    expect_lane("next_cycle_l0", 0, 1, 32'hA000, 0);
    expect_lane("next_cycle_l1", 1, 1, 32'hA000, 0);
    commit();

    apply(mk_req(1'b1, 32'h600), mk_req(1'b1, 32'h800), mk_fb(1'b1, 32'h800, 32'hB000), 1'b1);
    expect_lane("in_reset", 0, 0, 0, 0);
    commit();
    apply(mk_req(1'b1, 32'h600), mk_req(1'b1, 32'h800), no_fb, 1'b0);
    expect_lane("post_rst_old", 0, 0, 0, 0);
    expect_lane("post_rst_fb", 1, 0, 0, 0);
    commit();

    for (int i = 0; i < 800; i++) begin
      targ_pred_req_t r0, r1;
      targ_pred_fb_t  f;
      logic           rs;
      r0 = mk_req(($urandom_range(0, 9) < 8), 32'(($urandom_range(1, 8) << 8) | $urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) r1 = r0;
      else r1 = mk_req(($urandom_range(0, 9) < 8), 32'(($urandom_range(1, 8) << 8) | $urandom_range(0, 3)));
      f  = mk_fb($urandom_range(0, 1) == 1, 32'(($urandom_range(1, 8) << 8) | $urandom_range(0, 3)),
                 32'(($urandom_range(1, 5) << 12) | $urandom_range(0, 3)));
      rs = ($urandom_range(0, 99) == 0);
      step(r0, r1, f, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
